// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states and fetch constants.
package mips_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: synchronous flush beats hold, hold beats load.
module if_id_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc4,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= NOP_INSTR;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (!hold) begin
         instr <= load_instr;
         pc4   <= load_pc4;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, next-PC selection, fetch halt checks and IF/ID register.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ROM_SIZE = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic [31:0] imem_rdata,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        halted,
   output logic        fault_misaligned
);

   fetch_state_t state, state_next;
   logic [31:0]  pc_next;
   logic [31:0]  pc_plus4;
   logic         out_of_range;
   logic         hold;
   logic         flush;
   logic         fault_set;

   assign imem_addr    = {2'b00, pc[31:2]};
   assign pc_plus4     = pc + PC_STEP;
   assign out_of_range = imem_addr >= ROM_SIZE;
   assign halted       = (state == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= BOOT;
         pc               <= RESET_PC;
         fault_misaligned <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (fault_set)
            fault_misaligned <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      hold       = 1'b0;
      flush      = 1'b0;
      fault_set  = 1'b0;
      case (state)
         BOOT: begin
            state_next = RUN;
            pc_next    = pc_plus4;
         end
         RUN: begin
            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
               state_next = HALT;
               flush      = 1'b1;
               fault_set  = 1'b1;
            end else if (redirect_valid) begin
               pc_next = redirect_target;
               flush   = 1'b1;
            end else if (stall) begin
               hold = 1'b1;
            end else if (out_of_range) begin
               state_next = HALT;
               flush      = 1'b1;
            end else begin
               pc_next = pc_plus4;
            end
         end
         default: begin
            // HALT (and any illegal encoding) freezes everything until reset
            state_next = HALT;
            hold       = 1'b1;
         end
      endcase
   end

   if_id_reg u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .hold       (hold),
      .flush      (flush),
      .load_instr (imem_rdata),
      .load_pc4   (pc_plus4),
      .instr      (if_id_instr),
      .pc4        (if_id_pc4),
      .valid      (if_id_valid)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: default instance plus a ROM_SIZE=4 instance.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        rv = 1'b0;
   logic [31:0] rt = '0;
   logic        zero_bit = 1'b0;
   logic [31:0] zero_word = '0;

   logic [31:0] rdata [2];
   logic [31:0] addr [2];
   logic [31:0] pc_o [2];
   logic [31:0] instr_o [2];
   logic [31:0] pc4_o [2];
   logic        valid_o [2];
   logic        halted_o [2];
   logic        fault_o [2];

   logic [31:0] rom [64];
   int unsigned rs [2] = '{64, 4};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .ROM_SIZE(64)) u0 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(rv),
      .redirect_target(rt), .imem_rdata(rdata[0]), .imem_addr(addr[0]),
      .pc(pc_o[0]), .if_id_instr(instr_o[0]), .if_id_pc4(pc4_o[0]),
      .if_id_valid(valid_o[0]), .halted(halted_o[0]), .fault_misaligned(fault_o[0])
   );

   fetch_unit #(.RESET_PC(32'h0), .ROM_SIZE(4)) u1 (
      .clk(clk), .rst_n(rst_n), .stall(zero_bit), .redirect_valid(zero_bit),
      .redirect_target(zero_word), .imem_rdata(rdata[1]), .imem_addr(addr[1]),
      .pc(pc_o[1]), .if_id_instr(instr_o[1]), .if_id_pc4(pc4_o[1]),
      .if_id_valid(valid_o[1]), .halted(halted_o[1]), .fault_misaligned(fault_o[1])
   );

   function automatic logic [31:0] rom_word(int k, logic [31:0] idx);
      if (idx < rs[k] && idx < 64) return rom[idx[5:0]];
      return 32'h0;
   endfunction

   always_comb begin
      rdata[0] = rom_word(0, addr[0]);
      rdata[1] = rom_word(1, addr[1]);
   end

   // Behavioural model: phase 0 = boot, 1 = run, 2 = halt
   int          m_ph [2];
   logic [31:0] m_pc [2];
   logic [31:0] m_instr [2];
   logic [31:0] m_pc4 [2];
   logic        m_valid [2];
   logic        m_fault [2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         logic        s, r;
         logic [31:0] t;
         s = (k == 0) ? stall : 1'b0;
         r = (k == 0) ? rv : 1'b0;
         t = (k == 0) ? rt : 32'h0;
         if (!rst_n) begin
            m_ph[k] = 0; m_pc[k] = 32'h0; m_instr[k] = 0; m_pc4[k] = 0;
            m_valid[k] = 0; m_fault[k] = 0;
         end else if (m_ph[k] == 2) begin
         end else if (m_ph[k] == 1 && r && t[1:0] != 0) begin
            m_ph[k] = 2; m_fault[k] = 1;
            m_instr[k] = 0; m_pc4[k] = 0; m_valid[k] = 0;
         end else if (m_ph[k] == 1 && r) begin
            m_pc[k] = t; m_instr[k] = 0; m_pc4[k] = 0; m_valid[k] = 0;
         end else if (m_ph[k] == 1 && s) begin
         end else if (m_ph[k] == 1 && (m_pc[k] / 4) >= rs[k]) begin
            m_ph[k] = 2; m_instr[k] = 0; m_pc4[k] = 0; m_valid[k] = 0;
         end else begin
            m_instr[k] = rom_word(k, m_pc[k] / 4);
            m_pc4[k]   = m_pc[k] + 4;
            m_valid[k] = 1;
            m_pc[k]    = m_pc[k] + 4;
            m_ph[k]    = 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("pc[%0d]", k), pc_o[k], m_pc[k]);
            chk($sformatf("imem_addr[%0d]", k), addr[k], m_pc[k] / 4);
            chk($sformatf("instr[%0d]", k), instr_o[k], m_instr[k]);
            chk($sformatf("pc4[%0d]", k), pc4_o[k], m_pc4[k]);
            chk($sformatf("valid[%0d]", k), 32'(valid_o[k]), 32'(m_valid[k]));
            chk($sformatf("halted[%0d]", k), 32'(halted_o[k]), 32'(m_ph[k] == 2));
            chk($sformatf("fault[%0d]", k), 32'(fault_o[k]), 32'(m_fault[k]));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk({tag, "_pc"}, pc_o[k], 32'h0);
         chk({tag, "_instr"}, instr_o[k], 32'h0);
         chk({tag, "_pc4"}, pc4_o[k], 32'h0);
         chk({tag, "_valid"}, 32'(valid_o[k]), 32'h0);
         chk({tag, "_halted"}, 32'(halted_o[k]), 32'h0);
         chk({tag, "_fault"}, 32'(fault_o[k]), 32'h0);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | i;
      rom[0] = 32'h2008_0005;
      rom[1] = 32'h2009_0003;

      #12 chk_reset("reset");
      tick(); #2 rst_n = 1'b1;       // BOOT cycle runs
      tick();
      chk("boot_instr", instr_o[0], 32'h2008_0005);
      chk("boot_pc4", pc4_o[0], 32'd4);
      chk("boot_valid", 32'(valid_o[0]), 32'd1);
      tick();
      chk("w1_instr", instr_o[0], 32'h2009_0003);
      chk("w1_pc4", pc4_o[0], 32'd8);
      chk("w1_pc", pc_o[0], 32'd8);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", pc_o[0], 32'd8);
         chk("stall_pc4", pc4_o[0], 32'd8);
         chk("stall_instr", instr_o[0], 32'h2009_0003);
      end
      stall = 1'b0;
      tick();
      chk("post_stall_instr", instr_o[0], 32'h1000_0002);
      chk("post_stall_pc4", pc4_o[0], 32'd12);

      stall = 1'b1; rv = 1'b1; rt = 32'h20;
      tick();
      stall = 1'b0; rv = 1'b0;
      chk("redir_pc", pc_o[0], 32'h20);
      chk("redir_valid", 32'(valid_o[0]), 32'd0);
      chk("rom4_halted", 32'(halted_o[1]), 32'd1);
      chk("rom4_fault", 32'(fault_o[1]), 32'd0);
      chk("rom4_pc", pc_o[1], 32'd16);
      tick();
      chk("redir_instr", instr_o[0], 32'h1000_0008);
      chk("redir_pc4", pc4_o[0], 32'h24);
      tick(); tick();

      #2 rst_n = 1'b0;               // mid-run asynchronous reset
      #1 chk_reset("midrun_reset");
      tick(); #2 rst_n = 1'b1;
      tick();
      chk("restart_instr", instr_o[0], 32'h2008_0005);
      chk("restart_pc", pc_o[0], 32'd4);
      tick(); tick();

      rv = 1'b1; rt = 32'h22;
      tick();
      rv = 1'b0;
      chk("mis_halted", 32'(halted_o[0]), 32'd1);
      chk("mis_fault", 32'(fault_o[0]), 32'd1);
      chk("mis_valid", 32'(valid_o[0]), 32'd0);
      chk("mis_pc", pc_o[0], 32'd12);
      for (int i = 0; i < 4; i++) begin
         stall = i[0]; rv = ~i[0]; rt = 32'h40 + 32'(i * 4);
         tick();
      end
      stall = 1'b0; rv = 1'b0;
      chk("halt_frozen_pc", pc_o[0], 32'd12);
      chk("halt_frozen_halted", 32'(halted_o[0]), 32'd1);

      #2 rst_n = 1'b0;               // reset while halted
      #1 chk_reset("halt_reset");
      tick(); #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("final_rom4_pc", pc_o[1], 32'd16);
      chk("final_rom4_halted", 32'(halted_o[1]), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
